// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - RAW forwarding, load-use stall FSM and branch flush control
// Optional performance counters are built only when HU_PERF_CNT_EN is defined.
module hazard_unit #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_fd,
    input  logic [REG_AW-1:0] rs2_fd,
    input  logic [REG_AW-1:0] rs1_de,
    input  logic [REG_AW-1:0] rs2_de,
    input  logic [REG_AW-1:0] rd_de,
    input  logic              MemRd_de,
    input  logic [REG_AW-1:0] rd_me,
    input  logic              RUWr_me,
    input  logic [REG_AW-1:0] rd_wb,
    input  logic              RUWr_wb,
    input  logic              br_taken_ex,
    output logic [1:0]        rs1_exSrc,
    output logic [1:0]        rs2_exSrc,
    output logic              stall_pc,
    output logic              stall_fd,
    output logic              flush_fd,
    output logic              flush_de,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_STALL = 1'b1;

    localparam logic [1:0] SRC_RF = 2'b00;
    localparam logic [1:0] SRC_ME = 2'b01;
    localparam logic [1:0] SRC_WB = 2'b10;

    // First STALL-state cycle is the second bubble, hence the -2.
    localparam logic [3:0] CNT_INIT = (LOAD_LAT > 1) ? 4'(LOAD_LAT - 2) : 4'd0;

    logic       ld_stall_en;
    assign ld_stall_en = (LOAD_LAT > 1);

    logic [0:0] state_q, state_nxt;
    logic [3:0] cnt_q, cnt_nxt;
    logic       fwd1_me, fwd1_wb, fwd2_me, fwd2_wb;
    logic       load_use;

    // ME forwarding wins over WB because it carries the younger value.
    assign fwd1_me = RUWr_me && (rd_me != '0) && (rd_me == rs1_de);
    assign fwd1_wb = RUWr_wb && (rd_wb != '0) && (rd_wb == rs1_de);
    assign fwd2_me = RUWr_me && (rd_me != '0) && (rd_me == rs2_de);
    assign fwd2_wb = RUWr_wb && (rd_wb != '0) && (rd_wb == rs2_de);

    assign rs1_exSrc = fwd1_me ? SRC_ME : (fwd1_wb ? SRC_WB : SRC_RF);
    assign rs2_exSrc = fwd2_me ? SRC_ME : (fwd2_wb ? SRC_WB : SRC_RF);

    assign load_use = MemRd_de && (rd_de != '0) && ((rd_de == rs1_fd) || (rd_de == rs2_fd));

    always_comb begin
        stall_pc  = 1'b0;
        flush_fd  = 1'b0;
        flush_de  = 1'b0;
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        if (!rst) begin
            case (state_q)
                S_IDLE: begin
                    if (br_taken_ex) begin
                        flush_fd = 1'b1;
                        flush_de = 1'b1;
                    end else if (load_use) begin
                        stall_pc = 1'b1;
                        flush_de = 1'b1;
                        if (ld_stall_en) begin
                            state_nxt = S_STALL;
                            cnt_nxt   = CNT_INIT;
                        end
                    end
                end
                S_STALL: begin
                    if (br_taken_ex) begin
                        flush_fd  = 1'b1;
                        flush_de  = 1'b1;
                        state_nxt = S_IDLE;
                        cnt_nxt   = 4'd0;
                    end else begin
                        stall_pc = 1'b1;
                        flush_de = 1'b1;
                        if (cnt_q == 4'd0) begin
                            state_nxt = S_IDLE;
                        end else begin
                            cnt_nxt = cnt_q - 4'd1;
                        end
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = 4'd0;
                end
            endcase
        end
    end

    assign stall_fd = stall_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

`ifdef HU_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    // Saturating counters; only a reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_pc && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (flush_fd && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed bench for hazard_unit with LOAD_LAT=3 and LOAD_LAT=1 instances
module tb_hazard_unit;

`ifdef HU_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] rs1_fd, rs2_fd, rs1_de, rs2_de, rd_de, rd_me, rd_wb;
    logic       MemRd_de, RUWr_me, RUWr_wb, br_taken_ex;

    logic [1:0]  rs1_exSrc, rs2_exSrc, rs1_exSrc_b, rs2_exSrc_b;
    logic        stall_pc, stall_fd, flush_fd, flush_de;
    logic        stall_pc_b, stall_fd_b, flush_fd_b, flush_de_b;
    logic [31:0] stall_cnt, flush_cnt, stall_cnt_b, flush_cnt_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_unit #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .rs1_fd(rs1_fd), .rs2_fd(rs2_fd),
        .rs1_de(rs1_de), .rs2_de(rs2_de), .rd_de(rd_de), .MemRd_de(MemRd_de),
        .rd_me(rd_me), .RUWr_me(RUWr_me), .rd_wb(rd_wb), .RUWr_wb(RUWr_wb),
        .br_taken_ex(br_taken_ex),
        .rs1_exSrc(rs1_exSrc), .rs2_exSrc(rs2_exSrc),
        .stall_pc(stall_pc), .stall_fd(stall_fd),
        .flush_fd(flush_fd), .flush_de(flush_de),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_unit #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(32)) dut_b (
        .clk(clk), .rst(rst),
        .rs1_fd(rs1_fd), .rs2_fd(rs2_fd),
        .rs1_de(rs1_de), .rs2_de(rs2_de), .rd_de(rd_de), .MemRd_de(MemRd_de),
        .rd_me(rd_me), .RUWr_me(RUWr_me), .rd_wb(rd_wb), .RUWr_wb(RUWr_wb),
        .br_taken_ex(br_taken_ex),
        .rs1_exSrc(rs1_exSrc_b), .rs2_exSrc(rs2_exSrc_b),
        .stall_pc(stall_pc_b), .stall_fd(stall_fd_b),
        .flush_fd(flush_fd_b), .flush_de(flush_de_b),
        .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
    );

    task automatic clear_inputs();
        rs1_fd = 0; rs2_fd = 0; rs1_de = 0; rs2_de = 0; rd_de = 0;
        rd_me = 0; rd_wb = 0; MemRd_de = 0; RUWr_me = 0; RUWr_wb = 0;
        br_taken_ex = 0;
    endtask

    task automatic set_load_use();
        MemRd_de = 1; rd_de = 7; rs2_fd = 7;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        clear_inputs();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        set_load_use();
        br_taken_ex = 1;
        rd_me = 3; RUWr_me = 1; rs1_de = 3;
        @(negedge clk);
        #1;
        n_cmp++;
        if ({stall_pc, stall_fd, flush_fd, flush_de} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want 0000", {stall_pc, stall_fd, flush_fd, flush_de});
        end
        n_cmp++;
        if ({stall_pc_b, flush_fd_b, flush_de_b} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_ctrl_b: got %b want 000", {stall_pc_b, flush_fd_b, flush_de_b});
        end
        n_cmp++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            n_err++;
            $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
        end
        n_cmp++;
        if (rs1_exSrc !== 2'b01) begin
            n_err++;
            $display("FAIL reset_fwd: got %b want 01", rs1_exSrc);
        end
        @(negedge clk);
        clear_inputs();
        rst = 0;
        #1;
        n_cmp++;
        if ({stall_pc, flush_fd, flush_de} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_release: got %b want 000", {stall_pc, flush_fd, flush_de});
        end
    endtask

    task automatic test_forwarding();
        logic [4:0] v_rd_me [6] = '{5, 0, 4, 9, 0, 12};
        logic       v_we_me [6] = '{1, 1, 1, 0, 0, 1};
        logic [4:0] v_rd_wb [6] = '{5, 0, 4, 9, 8, 12};
        logic       v_we_wb [6] = '{1, 1, 1, 1, 1, 1};
        logic [4:0] v_rs1   [6] = '{5, 0, 3, 9, 8, 12};
        logic [4:0] v_rs2   [6] = '{6, 0, 4, 9, 8, 12};
        logic [1:0] e_rs1   [6] = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b10, 2'b01};
        logic [1:0] e_rs2   [6] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b10, 2'b01};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            clear_inputs();
            rd_me = v_rd_me[i]; RUWr_me = v_we_me[i];
            rd_wb = v_rd_wb[i]; RUWr_wb = v_we_wb[i];
            rs1_de = v_rs1[i]; rs2_de = v_rs2[i];
            #1;
            n_cmp++;
            if (rs1_exSrc !== e_rs1[i] || rs2_exSrc !== e_rs2[i]) begin
                n_err++;
                $display("FAIL fwd[%0d]: got %b/%b want %b/%b", i, rs1_exSrc, rs2_exSrc, e_rs1[i], e_rs2[i]);
            end
        end
        clear_inputs();
    endtask

    task automatic test_load_use();
        logic [3:0] exp_a = 4'b1110;
        logic [3:0] exp_b = 4'b1000;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            clear_inputs();
            if (c == 0) set_load_use();
            #1;
            n_cmp++;
            if ({stall_pc, stall_fd, flush_de, flush_fd} !== {exp_a[3-c], exp_a[3-c], exp_a[3-c], 1'b0}) begin
                n_err++;
                $display("FAIL load_use_lat3[%0d]: got %b want %b", c, {stall_pc, stall_fd, flush_de, flush_fd},
                         {exp_a[3-c], exp_a[3-c], exp_a[3-c], 1'b0});
            end
            n_cmp++;
            if ({stall_pc_b, stall_fd_b, flush_de_b, flush_fd_b} !== {exp_b[3-c], exp_b[3-c], exp_b[3-c], 1'b0}) begin
                n_err++;
                $display("FAIL load_use_lat1[%0d]: got %b want %b", c, {stall_pc_b, stall_fd_b, flush_de_b, flush_fd_b},
                         {exp_b[3-c], exp_b[3-c], exp_b[3-c], 1'b0});
            end
        end
        n_cmp++;
        if (stall_cnt !== (PERF ? 32'd3 : 32'd0) || stall_cnt_b !== (PERF ? 32'd1 : 32'd0)) begin
            n_err++;
            $display("FAIL load_use_cnt: got %0d/%0d want %0d/%0d", stall_cnt, stall_cnt_b,
                     PERF ? 3 : 0, PERF ? 1 : 0);
        end
    endtask

    task automatic test_branch_in_stall();
        do_reset();
        @(negedge clk);
        set_load_use();
        @(negedge clk);
        clear_inputs();
        br_taken_ex = 1;
        #1;
        n_cmp++;
        if ({stall_pc, stall_fd, flush_fd, flush_de} !== 4'b0011) begin
            n_err++;
            $display("FAIL br_in_stall: got %b want 0011", {stall_pc, stall_fd, flush_fd, flush_de});
        end
        @(negedge clk);
        br_taken_ex = 0;
        #1;
        n_cmp++;
        if ({stall_pc, flush_fd, flush_de} !== 3'b000) begin
            n_err++;
            $display("FAIL br_in_stall_idle: got %b want 000", {stall_pc, flush_fd, flush_de});
        end
        n_cmp++;
        if (flush_cnt !== (PERF ? 32'd1 : 32'd0) || stall_cnt !== (PERF ? 32'd1 : 32'd0)) begin
            n_err++;
            $display("FAIL br_in_stall_cnt: got %0d/%0d want %0d/%0d", flush_cnt, stall_cnt,
                     PERF ? 1 : 0, PERF ? 1 : 0);
        end
    endtask

    task automatic test_branch_vs_load();
        do_reset();
        @(negedge clk);
        set_load_use();
        br_taken_ex = 1;
        #1;
        n_cmp++;
        if ({stall_pc, stall_fd, flush_fd, flush_de} !== 4'b0011) begin
            n_err++;
            $display("FAIL br_vs_load: got %b want 0011", {stall_pc, stall_fd, flush_fd, flush_de});
        end
        @(negedge clk);
        clear_inputs();
        #1;
        n_cmp++;
        if ({stall_pc, flush_fd, flush_de} !== 3'b000) begin
            n_err++;
            $display("FAIL br_vs_load_next: got %b want 000", {stall_pc, flush_fd, flush_de});
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        // Hazard held for 5 cycles: LOAD_LAT=3 stalls all of them, LOAD_LAT=1 too.
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            clear_inputs();
            set_load_use();
            #1;
            n_cmp++;
            if (stall_pc !== 1'b1 || stall_pc_b !== 1'b1) begin
                n_err++;
                $display("FAIL back_to_back[%0d]: got %b/%b want 1/1", c, stall_pc, stall_pc_b);
            end
        end
        @(negedge clk);
        clear_inputs();
        #1;
        // Second hazard entered STALL at cycle 3, so LOAD_LAT=3 still has one bubble left.
        n_cmp++;
        if (stall_pc !== 1'b1 || stall_pc_b !== 1'b0) begin
            n_err++;
            $display("FAIL back_to_back_tail: got %b/%b want 1/0", stall_pc, stall_pc_b);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        @(negedge clk);
        set_load_use();
        @(negedge clk);
        clear_inputs();
        #1;
        n_cmp++;
        if (stall_pc !== 1'b1) begin
            n_err++;
            $display("FAIL mid_stall_pre: got %b want 1", stall_pc);
        end
        set_load_use();
        rst = 1;
        #1;
        n_cmp++;
        if ({stall_pc, stall_fd, flush_fd, flush_de} !== 4'b0000) begin
            n_err++;
            $display("FAIL mid_stall_rst: got %b want 0000", {stall_pc, stall_fd, flush_fd, flush_de});
        end
        @(negedge clk);
        clear_inputs();
        rst = 0;
        #1;
        n_cmp++;
        if (stall_pc !== 1'b0 || stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            n_err++;
            $display("FAIL mid_stall_post: got stall=%b cnt=%0d/%0d want 0 0/0", stall_pc, stall_cnt, flush_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch_in_stall();
        test_branch_vs_load();
        test_back_to_back();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Parametrised hazard unit for the pipelined RISC-V core: resolves RAW hazards by ME/WB forwarding with correct priority and x0 exclusion. Detects load-use hazards and inserts a configurable number of bubbles via a registered stall FSM. Flushes on taken branches. Sits beside the FD/DE/ME/WB pipeline registers and drives their stall/flush controls and the EX operand muxes.

## Interface
- REG_AW, 5: register address width.
- LOAD_LAT, 1: bubbles inserted per load-use hazard; legal range 1..15.
- CNT_W, 32: width of the performance counters.
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rs1_fd, rs2_fd  in  REG_AW  source registers of the instruction in decode.
- rs1_de, rs2_de, rd_de  in  REG_AW  sources and destination of the instruction in EX.
- MemRd_de  in  1  instruction in EX is a load.
- rd_me, RUWr_me  in  REG_AW, 1  ME-stage destination and register-write enable.
- rd_wb, RUWr_wb  in  REG_AW, 1  WB-stage destination and register-write enable.
- br_taken_ex  in  1  branch or jump resolved taken in EX.
- rs1_exSrc, rs2_exSrc  out  2  EX operand select: 00 register file, 01 ME, 10 WB.
- stall_pc, stall_fd  out  1  hold the PC and the FD register.
- flush_fd, flush_de  out  1  bubble the FD and DE registers.
- stall_cnt, flush_cnt  out  CNT_W  performance counters (see Configuration).

## Operation
- Forwarding is combinational and applies per source. For rs1, rs1_exSrc=01 if RUWr_me && rd_me!=0 && rd_me==rs1_de; else 10 if RUWr_wb && rd_wb!=0 && rd_wb==rs1_de; else 00. rs2 uses the same rule. ME has priority over WB.
- A load-use hazard exists when MemRd_de, rd_de!=0, and rd_de equals rs1_fd or rs2_fd.
  - Detection is conservative: the unit does not know whether the decode instruction actually uses the matching source.
- FSM states:
  - IDLE
    - Taken branch: flush_fd=flush_de=1. Stall outputs stay 0.
    - Else load-use hazard: stall_pc=stall_fd=flush_de=1. If LOAD_LAT>1, go to STALL with cnt=LOAD_LAT-2.
  - STALL
    - stall_pc=stall_fd=flush_de=1 regardless of the hazard inputs.
    - cnt decrements each cycle; returns to IDLE after the cycle with cnt==0.
- Simultaneous events:
  - Branch and load-use in the same cycle: the branch wins. Flush only, no stall, FSM stays IDLE.
  - br_taken_ex in STALL: flush_fd=flush_de=1, stall_* forced to 0, next state IDLE.
- Forwarding outputs are independent of FSM state.

## Timing
- Reset values: FSM=IDLE, cnt=0, stall_cnt=flush_cnt=0. All stall/flush outputs are 0 while in reset. exSrc outputs follow their combinational inputs.
- Forwarding and stall/flush outputs have zero latency: same cycle as their inputs.
- A load-use hazard produces exactly LOAD_LAT consecutive cycles of stall_pc high, starting in the detection cycle. There is no dead cycle before a new hazard is detected once back in IDLE.
- Reset asserted mid-STALL returns the FSM to IDLE immediately. Outputs are 0 until the first post-reset edge.

## Configuration
- HU_PERF_CNT_EN defined:
  - stall_cnt increments on each clock where stall_pc=1.
  - flush_cnt increments on each clock where a branch flush is issued.
  - Both saturate at 2^CNT_W-1 and clear only on rst.
- HU_PERF_CNT_EN undefined: no counter registers; stall_cnt and flush_cnt are tied to 0. Ports remain present.

## Test plan
- rd_me=5, RUWr_me=1, rd_wb=5, RUWr_wb=1, rs1_de=5, rs2_de=6 -> rs1_exSrc=01, rs2_exSrc=00 (ME priority).
- rd_me=0, RUWr_me=1, rs1_de=0, rd_wb=0, RUWr_wb=1 -> rs1_exSrc=00 (x0 never forwarded).
- LOAD_LAT=1: MemRd_de=1, rd_de=7, rs2_fd=7 for one cycle -> stall_pc/stall_fd/flush_de high for exactly 1 cycle; next cycle all 0.
- LOAD_LAT=3: same stimulus, then inputs cleared -> stall high for 3 cycles exactly; with HU_PERF_CNT_EN, stall_cnt=3.
- LOAD_LAT=3: br_taken_ex=1 in the second stall cycle -> that cycle flush_fd=flush_de=1, stall_pc=0; FSM IDLE next cycle; with HU_PERF_CNT_EN, flush_cnt=1.
- rst pulsed during STALL -> outputs 0 immediately, FSM IDLE, counters 0 after release.
